// File: rtl/sram_req_ctrl.sv
// Request front-end for the 128x32 SRAM macro: request FIFO, single-issue SRAM port, held read response.
// Optional SRAM_REQ_CTRL_STATS_EN adds saturating issued-read/write counters.
module sram_req_ctrl #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              init_done,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_r
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              sweep_done_q;
    req_t              fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic              req_ready_q, init_done_q;
    logic              resp_valid_q, resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              rd_pend_q;
    logic              sram_cs_q, sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;

    logic              fifo_empty, full_d, run_d, ready_d;
    logic              push, issue, resp_slot_ok;
    req_t              head;

    // A read owns the response register from issue until its response is taken.
    always_comb begin
        fifo_empty   = (wr_ptr_q == rd_ptr_q);
        head         = fifo_q[rd_ptr_q[IDX_W-1:0]];
        resp_slot_ok = !rd_pend_q && (!resp_valid_q || resp_ready);
        push         = req_valid && req_ready_q;
        issue        = (state_q == S_RUN) && !fifo_empty && (head.we || resp_slot_ok);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(issue);
        full_d       = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
                       (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
        run_d        = (state_q == S_RUN) || sweep_done_q;
        ready_d      = run_d && !full_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[IDX_W-1:0]] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
            cnt_q        <= '0;
            sweep_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            req_ready_q  <= 1'b0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            req_ready_q <= ready_d;
            init_done_q <= run_d;
            sram_cs_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            rd_pend_q   <= 1'b0;

            case (state_q)
                S_INIT: begin
                    if (!sweep_done_q) begin
                        sram_cs_q    <= 1'b1;
                        sram_we_q    <= 1'b1;
                        sram_addr_q  <= cnt_q;
                        sram_wdata_q <= '0;
                        if (cnt_q == LAST_ADDR) begin
                            sweep_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        sram_cs_q    <= 1'b1;
                        sram_we_q    <= head.we;
                        sram_addr_q  <= head.addr;
                        sram_wdata_q <= head.wdata;
                        rd_pend_q    <= !head.we;
                    end
                end
                default: state_q <= S_RUN;
            endcase

            // Capture the read issued last cycle; otherwise retire an accepted response.
            if (rd_pend_q) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= sram_rdata;
                resp_err_q   <= ~sram_r;
            end else if (resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

`ifdef SRAM_REQ_CTRL_STATS_EN
    logic [15:0] stat_rd_q, stat_wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else if (issue) begin
            if (head.we) begin
                if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
            end else begin
                if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

    assign req_ready  = req_ready_q;
    assign init_done  = init_done_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign sram_cs    = sram_cs_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: directed sweep/reset/latency/backpressure steps, then random traffic
// checked against a word-array memory model and an in-order expected-response queue.
module tb_sram_req_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        init_done;
    logic        sram_cs, sram_we;
    logic [6:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        sram_r;
`ifdef SRAM_REQ_CTRL_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

    logic        rand_mode, rnd_rdy, dir_rdy;
    logic [31:0] sram_mem [128];
    logic [31:0] mem_ref [128];
    rsp_t        exp_q[$];
    rsp_t        got_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          n_wr = 0;
    int          n_rd = 0;

    always #5 clk = ~clk;

    sram_req_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .init_done(init_done),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_r(sram_r)
`ifdef SRAM_REQ_CTRL_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
    );

    // SRAM macro stand-in: combinational read, synchronous write.
    assign sram_rdata = sram_mem[sram_addr];
    always @(posedge clk) if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_wdata;

    assign resp_ready = rand_mode ? rnd_rdy : dir_rdy;
    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 2) != 0);
    end

    // Record every completed response handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) got_q.push_back('{data: resp_rdata, err: resp_err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [6:0] a, input logic [31:0] d, input logic e_err);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 300 && !acc; i++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("accept", 64'(acc), 64'(1));
        if (acc) begin
            if (we) begin
                mem_ref[a] = d;
                n_wr++;
            end else begin
                exp_q.push_back('{data: mem_ref[a], err: e_err});
                n_rd++;
            end
        end
    endtask

    task automatic drain();
        rsp_t e, g;
        for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) tick();
        repeat (4) tick();
        chk("resp_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk("resp_data_err", 64'(g), 64'(e));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {req_ready, resp_valid, resp_err, init_done, sram_cs, sram_we},
            64'(0));
        chk(tag, {resp_rdata, 25'(0), sram_addr}, 64'(0));
        chk(tag, 64'(sram_wdata), 64'(0));
    endtask

    initial begin
        logic [31:0] wd;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        sram_r = 1'b1; dir_rdy = 1'b1; rand_mode = 1'b0;
        for (int i = 0; i < 128; i++) mem_ref[i] = 32'h0;

        repeat (2) tick();
        chk_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Partial sweep, then reset in cycle 40 must clear outputs asynchronously.
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("sweep1_pins", {sram_cs, sram_we, init_done, req_ready, sram_addr, sram_wdata},
                {1'b1, 1'b1, 1'b0, 1'b0, 7'(k), 32'h0});
        end
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_sweep_reset");
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 128; k++) begin
            tick();
            chk("sweep_pins", {sram_cs, sram_we, init_done, req_ready, sram_addr, sram_wdata},
                {1'b1, 1'b1, 1'b0, 1'b0, 7'(k), 32'h0});
        end
        tick();
        chk("run_entry", {init_done, req_ready, sram_cs, sram_we}, {1'b1, 1'b1, 1'b0, 1'b0});

        // Write then read-back of address 7, checking pin timing and two-edge read latency.
        send(1'b1, 7'd7, 32'hDEADBEEF, 1'b0);
        send(1'b0, 7'd7, 32'h0, 1'b0);
        chk("wr_pins", {sram_cs, sram_we, sram_addr, sram_wdata}, {1'b1, 1'b1, 7'd7, 32'hDEADBEEF});
        tick();
        chk("rd_pins", {sram_cs, sram_we, sram_addr, resp_valid}, {1'b1, 1'b0, 7'd7, 1'b0});
        tick();
        chk("rd_resp", {resp_valid, resp_err, resp_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        drain();
`ifdef SRAM_REQ_CTRL_STATS_EN
        chk("stat_mid", {stat_wr_cnt, stat_rd_cnt}, {16'd1, 16'd1});
`endif

        // Backpressure: five reads fill the response register plus four FIFO entries.
        for (int k = 0; k < 5; k++) begin
            wd = $urandom;
            send(1'b1, 7'(20 + k), wd, 1'b0);
        end
        drain();
        dir_rdy = 1'b0;
        for (int k = 0; k < 5; k++) send(1'b0, 7'(20 + k), 32'h0, 1'b0);
        chk("full_ready", 64'(req_ready), 64'(0));
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd25;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold", {req_ready, resp_valid, sram_cs, resp_rdata}, {1'b0, 1'b1, 1'b0, exp_q[0].data});
        end
        req_valid = 1'b0;
        chk("hold_no_handshake", 64'(got_q.size()), 64'(0));
        dir_rdy = 1'b1;
        drain();

        // A read sampled with sram_r low still completes, flagged as an error.
        sram_r = 1'b0;
        send(1'b0, 7'd3, 32'h0, 1'b1);
        drain();
        sram_r = 1'b1;

        // Random traffic over a small address window to exercise read-after-write ordering.
        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        drain();
        rand_mode = 1'b0;

`ifdef SRAM_REQ_CTRL_STATS_EN
        chk("stat_end", {stat_wr_cnt, stat_rd_cnt}, {16'(n_wr), 16'(n_rd)});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
